// File: rtl/unreorder_channel_pkg.sv
// Shared types and constants for the short-block unreorder stage:
// block modes, FSM states, band ranges and granule geometry.
package unreorder_channel_pkg;

  localparam int GRANULE_LINES    = 576;
  localparam int CB_W             = 5;
  localparam int WIDTH_W          = 8;
  localparam int SHORT_BANDS      = 13;
  localparam int MIXED_SHORT_BAND = 3;
  localparam int MIXED_START_LINE = 36;

  localparam logic [CB_W-1:0] SHORT_CB_FIRST = 5'd0;
  localparam logic [CB_W-1:0] SHORT_CB_STOP  = 5'd13;
  localparam logic [CB_W-1:0] MIXED_CB_FIRST = 5'd8;
  localparam logic [CB_W-1:0] MIXED_CB_STOP  = 5'd18;

  typedef enum logic [1:0] {
    MODE_SHORT = 2'd0,
    MODE_MIXED = 2'd1,
    MODE_LONG  = 2'd2
  } block_mode_t;

  typedef enum logic [3:0] {
    IDLE, COPY_P1, COPY_P2, COPY, REORDER_START, CB_WAIT,
    OFFSET_INIT, RD_FIRST, STREAM, OFFSET_INCR, CB_INCR, DONE
  } state_t;

  function automatic block_mode_t decode_mode(input logic       window_switching,
                                              input logic [1:0] block_type,
                                              input logic       mixed);
    if (window_switching && block_type == 2'd2)
      return mixed ? MODE_MIXED : MODE_SHORT;
    return MODE_LONG;
  endfunction

endpackage

// File: rtl/rom_scalefac_width.sv
// Short-block scalefactor band width ROM, registered output (one cycle latency).
// Mixed mode indexes cb 8..17 onto short bands 3..12.
module rom_scalefac_width
  import unreorder_channel_pkg::*;
(
  input  logic               clk,
  input  logic               enable,
  input  block_mode_t        mode,
  input  logic [1:0]         sampling_frequency,
  input  logic [CB_W-1:0]    cb,
  output logic [WIDTH_W-1:0] width
);

  // Band widths packed band 0 at the LSB: 44.1 kHz, 48 kHz, 32 kHz.
  localparam logic [8*SHORT_BANDS-1:0] WIDTHS_FS0 =
    {8'd56, 8'd30, 8'd22, 8'd18, 8'd14, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd4, 8'd4, 8'd4};
  localparam logic [8*SHORT_BANDS-1:0] WIDTHS_FS1 =
    {8'd66, 8'd26, 8'd20, 8'd16, 8'd14, 8'd12, 8'd10, 8'd6, 8'd6, 8'd4, 8'd4, 8'd4, 8'd4};
  localparam logic [8*SHORT_BANDS-1:0] WIDTHS_FS2 =
    {8'd12, 8'd42, 8'd34, 8'd26, 8'd20, 8'd16, 8'd12, 8'd8, 8'd6, 8'd4, 8'd4, 8'd4, 8'd4};

  logic [WIDTH_W-1:0] width_tab [0:3][0:SHORT_BANDS-1];
  logic [CB_W-1:0]    band;
  logic [3:0]         band_idx;

  genvar gi;
  generate
    for (gi = 0; gi < SHORT_BANDS; gi++) begin : g_band
      assign width_tab[0][gi] = WIDTHS_FS0[8*gi +: 8];
      assign width_tab[1][gi] = WIDTHS_FS1[8*gi +: 8];
      assign width_tab[2][gi] = WIDTHS_FS2[8*gi +: 8];
      assign width_tab[3][gi] = WIDTHS_FS0[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    band     = (mode == MODE_MIXED) ? cb - MIXED_CB_FIRST + CB_W'(MIXED_SHORT_BAND) : cb;
    band_idx = band[3:0];
  end

  always_ff @(posedge clk) begin
    if (enable)
      width <= (band < CB_W'(SHORT_BANDS)) ? width_tab[sampling_frequency][band_idx]
                                            : WIDTH_W'(1);
  end

endmodule

// File: rtl/unreorder_channel.sv
// Re-orders one channel from window-interleaved to band/window order (inverse of short-block reorder).
// Optional UNREORDER_WRITE_COUNT_EN adds a write_count output.
module unreorder_channel
  import unreorder_channel_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] granule_read_addr,
  input  logic [DATA_W-1:0] granule_read_data,
  output logic              granule_write_enable,
  output logic [ADDR_W-1:0] granule_write_addr,
  output logic [DATA_W-1:0] granule_write_data,
  input  logic [1:0]        header_sampling_frequency,
  input  logic [1:0]        sideinfo_block_type,
  input  logic              sideinfo_window_switching_flag,
  input  logic              sideinfo_mixed_block_flag,
  input  logic              channel_ready,
  output logic              channel_done
`ifdef UNREORDER_WRITE_COUNT_EN
  ,
  output logic [9:0]        write_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(GRANULE_LINES - 1);

  state_t             state_reg, state_next;
  block_mode_t        mode;
  logic [WIDTH_W-1:0] cb_width;

  logic [ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
  logic               wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0]  wr_data_reg, wr_data_next;
  logic [ADDR_W-1:0]  copy_cnt_reg, copy_cnt_next;
  logic [ADDR_W-1:0]  scale_reg, scale_next;
  logic [ADDR_W-1:0]  base_reg, base_next;
  logic [ADDR_W-1:0]  src_reg, src_next;
  logic [1:0]         offset_reg, offset_next;
  logic [WIDTH_W-1:0] cnt_reg, cnt_next;
  logic [CB_W-1:0]    cb_reg, cb_next;
  logic [CB_W-1:0]    cb_stop_reg, cb_stop_next;

  assign mode = decode_mode(sideinfo_window_switching_flag, sideinfo_block_type,
                            sideinfo_mixed_block_flag);

  rom_scalefac_width u_width_rom (
    .clk                (clk),
    .enable             (state_reg == CB_WAIT),
    .mode               (mode),
    .sampling_frequency (header_sampling_frequency),
    .cb                 (cb_reg),
    .width              (cb_width)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:          if (channel_ready) state_next = COPY_P1;
      COPY_P1:       state_next = COPY_P2;
      COPY_P2:       state_next = COPY;
      COPY:          if (copy_cnt_reg == LAST_LINE)
                       state_next = (mode == MODE_LONG) ? DONE : REORDER_START;
      REORDER_START: state_next = CB_WAIT;
      CB_WAIT:       state_next = OFFSET_INIT;
      OFFSET_INIT:   state_next = RD_FIRST;
      RD_FIRST:      state_next = STREAM;
      STREAM:        if (cnt_reg + WIDTH_W'(1) == cb_width) state_next = OFFSET_INCR;
      OFFSET_INCR:   state_next = (offset_reg != 2'd2) ? OFFSET_INIT : CB_INCR;
      CB_INCR:       state_next = (cb_reg + CB_W'(1) < cb_stop_reg) ? CB_WAIT : DONE;
      DONE:          state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_addr_next  = rd_addr_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    copy_cnt_next = copy_cnt_reg;
    scale_next    = scale_reg;
    base_next     = base_reg;
    src_next      = src_reg;
    offset_next   = offset_reg;
    cnt_next      = cnt_reg;
    cb_next       = cb_reg;
    cb_stop_next  = cb_stop_reg;
    case (state_reg)
      IDLE:    if (channel_ready) copy_cnt_next = '0;
      COPY_P1: rd_addr_next = '0;
      COPY_P2: rd_addr_next = ADDR_W'(1);
      COPY: begin
        // Read data always belongs to the address one ahead of copy_cnt minus one.
        wr_en_next    = 1'b1;
        wr_addr_next  = copy_cnt_reg;
        wr_data_next  = granule_read_data;
        copy_cnt_next = copy_cnt_reg + ADDR_W'(1);
        rd_addr_next  = (rd_addr_reg == LAST_LINE) ? rd_addr_reg : rd_addr_reg + ADDR_W'(1);
      end
      REORDER_START: begin
        if (mode == MODE_MIXED) begin
          scale_next   = ADDR_W'(MIXED_START_LINE);
          cb_next      = MIXED_CB_FIRST;
          cb_stop_next = MIXED_CB_STOP;
        end else begin
          scale_next   = '0;
          cb_next      = SHORT_CB_FIRST;
          cb_stop_next = SHORT_CB_STOP;
        end
      end
      CB_WAIT: begin
        base_next   = scale_reg;
        offset_next = 2'd0;
      end
      OFFSET_INIT: begin
        rd_addr_next = base_reg + ADDR_W'(offset_reg);
        src_next     = base_reg + ADDR_W'(offset_reg) + ADDR_W'(3);
        cnt_next     = '0;
      end
      RD_FIRST: begin
        if (cb_width > WIDTH_W'(1)) begin
          rd_addr_next = src_reg;
          src_next     = src_reg + ADDR_W'(3);
        end
      end
      STREAM: begin
        wr_en_next   = 1'b1;
        wr_addr_next = scale_reg;
        wr_data_next = granule_read_data;
        scale_next   = scale_reg + ADDR_W'(1);
        cnt_next     = cnt_reg + WIDTH_W'(1);
        // One read is already in flight, so only prefetch while two or more lines remain.
        if ((WIDTH_W+1)'(cnt_reg) + (WIDTH_W+1)'(2) < (WIDTH_W+1)'(cb_width)) begin
          rd_addr_next = src_reg;
          src_next     = src_reg + ADDR_W'(3);
        end
      end
      OFFSET_INCR: if (offset_reg != 2'd2) offset_next = offset_reg + 2'd1;
      CB_INCR:     if (cb_reg + CB_W'(1) < cb_stop_reg) cb_next = cb_reg + CB_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_reg  <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      copy_cnt_reg <= '0;
      scale_reg    <= '0;
      base_reg     <= '0;
      src_reg      <= '0;
      offset_reg   <= '0;
      cnt_reg      <= '0;
      cb_reg       <= '0;
      cb_stop_reg  <= '0;
    end else begin
      rd_addr_reg  <= rd_addr_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      copy_cnt_reg <= copy_cnt_next;
      scale_reg    <= scale_next;
      base_reg     <= base_next;
      src_reg      <= src_next;
      offset_reg   <= offset_next;
      cnt_reg      <= cnt_next;
      cb_reg       <= cb_next;
      cb_stop_reg  <= cb_stop_next;
    end
  end

  always_comb begin
    granule_read_addr    = rd_addr_reg;
    granule_write_enable = wr_en_reg;
    granule_write_addr   = wr_addr_reg;
    granule_write_data   = wr_data_reg;
    channel_done         = (state_reg == DONE);
  end

`ifdef UNREORDER_WRITE_COUNT_EN
  // Ten bits wrap modulo 1024 on the two-pass short and mixed jobs.
  logic [9:0] write_count_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    write_count_reg <= '0;
    else if (state_reg == IDLE && channel_ready) write_count_reg <= '0;
    else if (wr_en_reg)                          write_count_reg <= write_count_reg + 10'd1;
  end
  assign write_count = write_count_reg;
`endif

endmodule

// File: tb/tb_unreorder_channel.sv
// Directed bench for unreorder_channel: long copy, short/mixed reorder, round trip,
// mid-job reset and ready robustness, checked against a band-boundary model.
module tb_unreorder_channel;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 10;
  localparam int LINES  = 576;
  localparam int M_SHORT = 0, M_MIXED = 1, M_LONG = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] granule_read_addr;
  logic [DATA_W-1:0] granule_read_data;
  logic              granule_write_enable;
  logic [ADDR_W-1:0] granule_write_addr;
  logic [DATA_W-1:0] granule_write_data;
  logic [1:0]        header_sampling_frequency;
  logic [1:0]        sideinfo_block_type;
  logic              sideinfo_window_switching_flag;
  logic              sideinfo_mixed_block_flag;
  logic              channel_ready;
  logic              channel_done;
`ifdef UNREORDER_WRITE_COUNT_EN
  logic [9:0]        write_count;
`endif

  always #5 clk = ~clk;

  unreorder_channel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .granule_read_addr              (granule_read_addr),
    .granule_read_data              (granule_read_data),
    .granule_write_enable           (granule_write_enable),
    .granule_write_addr             (granule_write_addr),
    .granule_write_data             (granule_write_data),
    .header_sampling_frequency      (header_sampling_frequency),
    .sideinfo_block_type            (sideinfo_block_type),
    .sideinfo_window_switching_flag (sideinfo_window_switching_flag),
    .sideinfo_mixed_block_flag      (sideinfo_mixed_block_flag),
    .channel_ready                  (channel_ready),
    .channel_done                   (channel_done)
`ifdef UNREORDER_WRITE_COUNT_EN
    ,
    .write_count                    (write_count)
`endif
  );

  logic [DATA_W-1:0] in_mem  [0:LINES-1];
  logic [DATA_W-1:0] out_mem [0:LINES-1];
  logic [DATA_W-1:0] exp_mem [0:LINES-1];
  logic [DATA_W-1:0] orig    [0:LINES-1];
  int                hits    [0:LINES-1];
  int                bnd     [0:2][0:13];
  int checks = 0, errors = 0;
  int strobes, dones, oob;

  // Input granule RAM: registered read, data valid one cycle after address.
  always @(posedge clk)
    granule_read_data <= (granule_read_addr < ADDR_W'(LINES)) ? in_mem[granule_read_addr] : '0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_mode(input int m, input int fs);
    header_sampling_frequency = 2'(fs);
    case (m)
      M_SHORT: begin sideinfo_window_switching_flag = 1; sideinfo_block_type = 2; sideinfo_mixed_block_flag = 0; end
      M_MIXED: begin sideinfo_window_switching_flag = 1; sideinfo_block_type = 2; sideinfo_mixed_block_flag = 1; end
      default: begin sideinfo_window_switching_flag = 1; sideinfo_block_type = 1; sideinfo_mixed_block_flag = 1; end
    endcase
  endtask

  // Window-interleaved input -> band-ordered expected output.
  task automatic build_expected(input int m, input int fs);
    int lo, w;
    for (int k = 0; k < LINES; k++) exp_mem[k] = in_mem[k];
    if (m == M_LONG) return;
    for (int b = (m == M_MIXED) ? 3 : 0; b < 13; b++) begin
      lo = 3 * bnd[fs][b];
      w  = bnd[fs][b+1] - bnd[fs][b];
      for (int win = 0; win < 3; win++)
        for (int i = 0; i < w; i++)
          exp_mem[lo + win*w + i] = in_mem[lo + win + 3*i];
    end
  endtask

  // Band-ordered original -> window-interleaved decoder layout.
  task automatic interleave_orig(input int m, input int fs);
    int lo, w;
    for (int k = 0; k < LINES; k++) in_mem[k] = orig[k];
    for (int b = (m == M_MIXED) ? 3 : 0; b < 13; b++) begin
      lo = 3 * bnd[fs][b];
      w  = bnd[fs][b+1] - bnd[fs][b];
      for (int win = 0; win < 3; win++)
        for (int i = 0; i < w; i++)
          in_mem[lo + win + 3*i] = orig[lo + win*w + i];
    end
  endtask

  task automatic run_job(input int ready_cycles, input int repulse_at, input int abort_at);
    int  done_cyc;
    bit  finished;
    strobes = 0; dones = 0; oob = 0; done_cyc = -1; finished = 0;
    for (int k = 0; k < LINES; k++) begin hits[k] = 0; out_mem[k] = '0; end
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      if (granule_write_enable) begin
        strobes++;
        if (granule_write_addr < ADDR_W'(LINES)) begin
          hits[granule_write_addr]++;
          out_mem[granule_write_addr] = granule_write_data;
        end else oob++;
      end
      if (channel_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == abort_at) begin
        rst = 1'b0;
        finished = 1;
      end else begin
        channel_ready = (cyc < ready_cycles) || (cyc == repulse_at);
        if (done_cyc >= 0 && cyc >= done_cyc + 6) finished = 1;
      end
    end
    channel_ready = 1'b0;
    if (abort_at < 0) check("job_done_seen", int'(done_cyc >= 0), 1);
  endtask

  task automatic check_job(input string tag, input int m, input int exp_strobes);
    int mism, badhits, want;
    mism = 0; badhits = 0;
    for (int k = 0; k < LINES; k++) begin
      if (out_mem[k] !== exp_mem[k]) mism++;
      want = (m == M_LONG || (m == M_MIXED && k < 36)) ? 1 : 2;
      if (hits[k] != want) badhits++;
    end
    $display("job %s strobes=%0d dones=%0d", tag, strobes, dones);
    check({tag, "_model"}, mism, 0);
    check({tag, "_hits"}, badhits + oob, 0);
    check({tag, "_strobes"}, strobes, exp_strobes);
    check({tag, "_dones"}, dones, 1);
`ifdef UNREORDER_WRITE_COUNT_EN
    check({tag, "_write_count"}, int'(write_count), exp_strobes % 1024);
`endif
  endtask

  int short_spot [0:12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11, 12};
  int mism;

  initial begin
    bnd[0] = '{0, 4, 8, 12, 16, 22, 30, 40, 52, 66, 84, 106, 136, 192};
    bnd[1] = '{0, 4, 8, 12, 16, 22, 28, 38, 50, 64, 80, 100, 126, 192};
    bnd[2] = '{0, 4, 8, 12, 16, 22, 30, 42, 58, 78, 104, 138, 180, 192};
    for (int k = 0; k < LINES; k++) in_mem[k] = DATA_W'(k);
    rst = 1'b0; channel_ready = 1'b0;
    set_mode(M_LONG, 0);
    repeat (3) @(negedge clk);
    check("reset_read_addr", int'(granule_read_addr), 0);
    check("reset_write_en", int'(granule_write_enable), 0);
    check("reset_write_addr", int'(granule_write_addr), 0);
    check("reset_write_data", int'(granule_write_data), 0);
    check("reset_done", int'(channel_done), 0);
    rst = 1'b1;
    @(negedge clk);

    // Long block: straight copy.
    set_mode(M_LONG, 0);
    build_expected(M_LONG, 0);
    run_job(1, -1, -1);
    check_job("long", M_LONG, 576);

    // Short block, 44.1 kHz table.
    set_mode(M_SHORT, 0);
    build_expected(M_SHORT, 0);
    run_job(1, -1, -1);
    for (int k = 0; k < 13; k++) check($sformatf("short_out%0d", k), int'(out_mem[k]), short_spot[k]);
    check_job("short_fs0", M_SHORT, 1152);

    // Mixed block: long prefix kept, then short bands from line 36.
    set_mode(M_MIXED, 0);
    build_expected(M_MIXED, 0);
    run_job(1, -1, -1);
    mism = 0;
    for (int k = 0; k < 36; k++) if (out_mem[k] !== DATA_W'(k)) mism++;
    check("mixed_prefix", mism, 0);
    check("mixed_out36", int'(out_mem[36]), 36);
    check("mixed_out37", int'(out_mem[37]), 39);
    check("mixed_out38", int'(out_mem[38]), 42);
    check("mixed_out575", int'(out_mem[575]), int'(exp_mem[575]));
    check_job("mixed_fs0", M_MIXED, 1116);

    // Round trip through the decoder-side interleave for every table.
    for (int fs = 0; fs < 3; fs++) begin
      for (int m = M_SHORT; m <= M_MIXED; m++) begin
        for (int k = 0; k < LINES; k++) orig[k] = DATA_W'($urandom_range(0, 262143));
        interleave_orig(m, fs);
        set_mode(m, fs);
        run_job(1, -1, -1);
        mism = 0;
        for (int k = 0; k < LINES; k++) if (out_mem[k] !== orig[k]) mism++;
        $display("job roundtrip mode=%0d fs=%0d strobes=%0d dones=%0d", m, fs, strobes, dones);
        check($sformatf("roundtrip_m%0d_fs%0d", m, fs), mism, 0);
        check($sformatf("roundtrip_m%0d_fs%0d_dones", m, fs), dones, 1);
      end
    end

    // Reset during the reorder phase, then a clean job.
    for (int k = 0; k < LINES; k++) in_mem[k] = DATA_W'(k);
    set_mode(M_SHORT, 1);
    build_expected(M_SHORT, 1);
    run_job(1, -1, 700);
    #1;
    $display("job abort strobes=%0d dones=%0d", strobes, dones);
    check("abort_in_reorder", int'(strobes > 576), 1);
    check("abort_no_done", dones, 0);
    check("abort_read_addr", int'(granule_read_addr), 0);
    check("abort_write_en", int'(granule_write_enable), 0);
    check("abort_write_addr", int'(granule_write_addr), 0);
    check("abort_write_data", int'(granule_write_data), 0);
    mism = 0;
    repeat (3) begin
      @(negedge clk);
      if (channel_done || granule_write_enable) mism++;
    end
    check("abort_held_quiet", mism, 0);
    rst = 1'b1;
    @(negedge clk);
    run_job(1, -1, -1);
    check_job("after_abort", M_SHORT, 1152);

    // Ready held three cycles and re-pulsed mid-job: still one job.
    set_mode(M_SHORT, 2);
    build_expected(M_SHORT, 2);
    run_job(3, 300, -1);
    check_job("ready_hold", M_SHORT, 1152);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
